// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: blank pattern, hex decode table and digit width.
// SEG_HEX_DECODE_EN selects 4-bit hex digit inputs instead of 7-bit raw segment patterns.
package seg_scan_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef SEG_HEX_DECODE_EN
   localparam int DIG_W = 4;
`else
   localparam int DIG_W = 7;
`endif

   // Active-low {g,f,e,d,c,b,a} patterns for hex values 0..F.
   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      return HEX_SEG_TABLE[value];
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational hex-to-seven-segment decoder; only built when SEG_HEX_DECODE_EN is defined.
`ifdef SEG_HEX_DECODE_EN
module hex7seg
   import seg_scan_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(hex_i);

endmodule
`endif

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with PWM brightness, dead phase and frame-aligned shadow loading.
// SEG_HEX_DECODE_EN: digits are 4-bit hex values decoded through hex7seg instead of raw patterns.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   parameter  int DUTY_BITS  = 3,
   localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clk_en,
   input  logic [DIG_W*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]       dp,
   input  logic [NUM_DIGITS-1:0]       blank,
   input  logic [DUTY_BITS-1:0]        brightness,
   input  logic                        load,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [6:0]                  seg,
   output logic                        dp_n,
   output logic [SEL_W-1:0]            sel,
   output logic                        frame_start
);

   localparam logic [DUTY_BITS-1:0] PHASE_MAX = '1;
   localparam logic [SEL_W-1:0]     SEL_MAX   = SEL_W'(NUM_DIGITS - 1);

   logic [DUTY_BITS-1:0]        phase_q, phase_d;
   logic [DUTY_BITS-1:0]        bri_q, bri_d;
   logic [SEL_W-1:0]            sel_q, sel_d;
   logic                        pending_q;
   logic [DIG_W*NUM_DIGITS-1:0] stg_dig_q, act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]       stg_dp_q, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]       stg_blank_q, act_blank_q, act_blank_d;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dp_n_q, dp_n_d;
   logic                        frame_start_q;

   logic                        wrap, boundary, anode_on;
   logic [DIG_W-1:0]            cur_digit;
   logic [6:0]                  pattern;

   assign wrap     = clk_en && (phase_q == PHASE_MAX);
   assign boundary = wrap && (sel_q == SEL_MAX);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      phase_d     = phase_q;
      sel_d       = sel_q;
      bri_d       = bri_q;
      act_dig_d   = act_dig_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      if (clk_en) phase_d = phase_q + 1'b1;
      if (wrap) begin
         bri_d = brightness;
         sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      end
      // A load on the boundary tick bypasses staging so it is never a frame late.
      if (boundary && load) begin
         act_dig_d   = digits;
         act_dp_d    = dp;
         act_blank_d = blank;
      end else if (boundary && pending_q) begin
         act_dig_d   = stg_dig_q;
         act_dp_d    = stg_dp_q;
         act_blank_d = stg_blank_q;
      end
   end

   // Outputs are decoded from next-state values so they line up with the counter registers.
   assign cur_digit = act_dig_d[DIG_W*sel_d +: DIG_W];
   assign anode_on  = (phase_d != '0) && (phase_d <= bri_d) && !act_blank_d[sel_d];

`ifdef SEG_HEX_DECODE_EN
   hex7seg u_hex7seg (
      .hex_i (cur_digit),
      .seg_o (pattern)
   );
`else
   assign pattern = cur_digit;
`endif

   always_comb begin
      an_d   = anode_on ? ~(NUM_DIGITS'(1) << sel_d) : '1;
      seg_d  = anode_on ? pattern : SEG_BLANK;
      dp_n_d = !(anode_on && act_dp_d[sel_d]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the small staging/active register sets are reset so the display starts blanked.
         phase_q       <= '0;
         sel_q         <= '0;
         bri_q         <= '0;
         pending_q     <= 1'b0;
         stg_dig_q     <= '0;
         act_dig_q     <= '0;
         stg_dp_q      <= '0;
         act_dp_q      <= '0;
         stg_blank_q   <= '1;
         act_blank_q   <= '1;
         an_q          <= '1;
         seg_q         <= SEG_BLANK;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         sel_q         <= sel_d;
         bri_q         <= bri_d;
         act_dig_q     <= act_dig_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         frame_start_q <= boundary;
         if (load) begin
            stg_dig_q   <= digits;
            stg_dp_q    <= dp;
            stg_blank_q <= blank;
            pending_q   <= !boundary;
         end else if (boundary) begin
            pending_q <= 1'b0;
         end
         if (clk_en) begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
         end
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp_n        = dp_n_q;
   assign sel         = sel_q;
   assign frame_start = frame_start_q;

endmodule
